bit_stream_serializer: RTL and testbench
========================================

BIT_STREAM_SERIALIZER -- requirements
Module: bit_stream_serializer

Interface
REQ-001 SHALL have parameter DATA_W, default 8; word width in bits.
REQ-002 SHALL have parameter LEN_W, default 4; width of the length field, with 2**LEN_W > DATA_W.
REQ-003 SHALL have port clock, input, 1; the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1; synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1; upstream word offered.
REQ-006 SHALL have port in_ready, output, 1; block can accept a word this cycle.
REQ-007 SHALL have port in_data, input, DATA_W; word to serialise.
REQ-008 SHALL have port in_len, input, LEN_W; number of bits to send; 0 means DATA_W; values above DATA_W are clamped to DATA_W.
REQ-009 SHALL have port sequence_out, output, 1; serial bit, which feeds the sequence detector's sequence_in.
REQ-010 SHALL have port bit_valid, output, 1; sequence_out carries a payload bit this cycle.
REQ-011 SHALL have port word_done, output, 1; one-cycle pulse coincident with the last bit of each word.
REQ-012 SHALL have port busy, output, 1; shifter or hold buffer occupied.

Function
REQ-013 SHALL accept a word on a rising edge where in_valid && in_ready.
REQ-014 SHALL send bits in_data[len-1] down to in_data[0], MSB-first; upper bits are ignored.
REQ-015 SHALL register all outputs; the first bit of a word accepted at edge k appears in the cycle after edge k when the shifter is idle.
REQ-016 SHALL provide a shift register plus one-entry hold buffer; in_ready = !hold_full.
REQ-017 SHALL use FSM states IDLE and SHIFT.
  - IDLE -> SHIFT: on load.
  - SHIFT -> SHIFT: on last bit with a next word available.
  - SHIFT -> IDLE: on last bit with no word available.
REQ-018 SHALL load the shifter on an edge where it is idle or presenting its last bit.
  - Source is the hold buffer if full, else the accepted input.
  - An accepted input not taken by the shifter goes to the hold buffer.
REQ-019 SHALL send back-to-back words with no gap: the last bit of word N is followed directly by the first bit of word N+1.
REQ-020 SHALL drive sequence_out=0 and bit_valid=0 in IDLE.
REQ-021 SHALL assert word_done for exactly one cycle per word, concurrent with bit_valid.
REQ-022 SHALL assert busy when state==SHIFT or hold_full.
REQ-023 SHALL handle a 1-bit word (in_len=1): one bit_valid cycle, with word_done in the same cycle.
REQ-024 SHALL use a bit counter LEN_W wide that counts down to 1, with no wrap-around.

Reset
REQ-025 SHALL, while reset is high at a clock edge, force state=IDLE, hold_full=0, sequence_out=0, bit_valid=0, word_done=0, busy=0; in_ready then reads 1.
REQ-026 SHALL make a reset during a word abort it: remaining bits and held word discarded, no word_done.
REQ-027 SHALL ignore in_valid on any edge where reset is high.

Structure
REQ-028 SHALL place DATA_W and LEN_W defaults plus the state enum (IDLE, SHIFT) in shared package seq_pkg.
REQ-029 SHALL use one sub-module, ser_hold_buf: a one-entry data+length register with full flag, load and take.
REQ-030 SHALL keep the shifter, counter and FSM in the top module.

Verification
REQ-031 SHALL cover: after reset, in_data=8'h0B, in_len=4 -> sequence_out 1,0,1,1 over 4 cycles, bit_valid high 4 cycles, word_done on the 4th, then IDLE.
REQ-032 SHALL cover: in_len=0, in_data=8'hA5 -> 8 bits 1,0,1,0,0,1,0,1; word_done on the 8th.
REQ-033 SHALL cover: words 8'h0B/len4 then 8'h02/len2, in_valid held high -> 6 contiguous bit_valid cycles 1,0,1,1,1,0; in_ready low while the hold buffer is full.
REQ-034 SHALL cover: three words offered continuously -> third accepted only after the first's last bit; no bit lost or duplicated.
REQ-035 SHALL cover: reset asserted at the 3rd bit of an 8-bit word with a held word -> next cycle bit_valid=0, busy=0, in_ready=1, no word_done.
REQ-036 SHALL cover end-to-end: drive sequence_out into the detector with 8'h0B, len4 -> detector_out=1 one cycle after the last bit.

Source files
------------

// File: rtl/bit_stream_serializer_pkg.sv
// Shared definitions for the bit-stream serializer slice.
// Provides the default word/length widths and the serializer FSM state type.
// The package is named seq_pkg because the downstream sequence detector
// imports the same definitions.
package seq_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int LEN_W_DEF  = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

endpackage

// File: rtl/bit_stream_serializer_if.sv
// Word-in / bit-out bus of the bit-stream serializer.
//   in_valid/in_ready : upstream word handshake
//   in_data/in_len    : word and number of bits to send (0 = DATA_W)
//   sequence_out      : serial bit (MSB-first), bit_valid qualifies it
//   word_done         : pulse with the last bit of each word
//   busy              : shifter or hold buffer occupied
// master = word producer, slave = serializer.
interface bit_stream_serializer_if
  import seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [LEN_W-1:0]  in_len;
  logic              sequence_out;
  logic              bit_valid;
  logic              word_done;
  logic              busy;

  modport master (
    output in_valid, in_data, in_len,
    input  in_ready, sequence_out, bit_valid, word_done, busy
  );

  modport slave (
    input  in_valid, in_data, in_len,
    output in_ready, sequence_out, bit_valid, word_done, busy
  );

endinterface

// File: rtl/bit_stream_serializer_hold_buf.sv
// ser_hold_buf: one-entry data+length register with a full flag.
//   clock, reset : clock and synchronous active-high reset (clears full only)
//   i_load       : capture i_data/i_len and mark full
//   i_take       : the consumer has taken the entry this edge
//   o_full       : entry valid
//   o_data/o_len : stored word and its (already clamped) length
module ser_hold_buf
  import seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_load,
  input  logic              i_take,
  input  logic [DATA_W-1:0] i_data,
  input  logic [LEN_W-1:0]  i_len,
  output logic              o_full,
  output logic [DATA_W-1:0] o_data,
  output logic [LEN_W-1:0]  o_len
);

  logic              r_full;
  logic [DATA_W-1:0] r_data;
  logic [LEN_W-1:0]  r_len;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_full <= 1'b0;
    end else begin
      r_full <= i_load | (r_full & ~i_take);
    end
  end

  always_ff @(posedge clock) begin
    if (i_load) begin
      r_data <= i_data;
      r_len  <= i_len;
    end
  end

  assign o_full = r_full;
  assign o_data = r_data;
  assign o_len  = r_len;

endmodule

// File: rtl/bit_stream_serializer.sv
// bit_stream_serializer: turns words into an MSB-first serial bit stream.
//   clock : single clock, rising edge
//   reset : synchronous active-high reset; aborts any word in flight
//   bus   : slave side of bit_stream_serializer_if (word handshake in,
//           sequence_out/bit_valid/word_done/busy out)
// A shift register presents one bit per cycle; a one-entry hold buffer lets
// the next word be queued so consecutive words leave with no gap.
module bit_stream_serializer
  import seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic                   clock,
  input  logic                   reset,
  bit_stream_serializer_if.slave bus
);

  // 0 and anything wider than the word both mean "send the whole word".
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    if (len == '0 || int'(len) > DATA_W) return LEN_W'(DATA_W);
    return len;
  endfunction

  ser_state_t        r_state;
  ser_state_t        w_state_nxt;
  logic [DATA_W-1:0] r_shift;
  logic [LEN_W-1:0]  r_cnt;
  logic              r_out_bit;
  logic              r_bit_valid;
  logic              r_word_done;
  logic              r_busy;

  logic              w_full;
  logic [DATA_W-1:0] w_hold_data;
  logic [LEN_W-1:0]  w_hold_len;
  logic              w_accept;
  logic              w_can_load;
  logic              w_load;
  logic              w_take;
  logic              w_hold_load;
  logic              w_hold_full_nxt;
  logic [DATA_W-1:0] w_src_data;
  logic [LEN_W-1:0]  w_src_len;
  logic [DATA_W-1:0] w_aligned;

  logic [DATA_W-1:0] w_shift_nxt;
  logic [LEN_W-1:0]  w_cnt_nxt;
  logic              w_out_nxt;
  logic              w_vld_nxt;
  logic              w_done_nxt;

  // r_cnt counts the bits still to present including the current one, so
  // r_cnt == 1 marks the last bit of the word.
  assign w_accept        = bus.in_valid & ~w_full & ~reset;
  assign w_can_load      = (r_state == IDLE) || (r_cnt == LEN_W'(1));
  assign w_load          = w_can_load & (w_full | w_accept);
  assign w_take          = w_can_load & w_full;
  assign w_hold_load     = w_accept & ~w_can_load;
  assign w_hold_full_nxt = w_hold_load | (w_full & ~w_take);

  // The held word is older than anything on the input, so it goes first.
  assign w_src_data = w_full ? w_hold_data : bus.in_data;
  assign w_src_len  = w_full ? w_hold_len  : clamp_len(bus.in_len);
  // Left-justify the payload so its first bit sits at the MSB.
  assign w_aligned  = w_src_data << (DATA_W - int'(w_src_len));

  ser_hold_buf #(
    .DATA_W (DATA_W),
    .LEN_W  (LEN_W)
  ) u_hold (
    .clock  (clock),
    .reset  (reset),
    .i_load (w_hold_load),
    .i_take (w_take),
    .i_data (bus.in_data),
    .i_len  (clamp_len(bus.in_len)),
    .o_full (w_full),
    .o_data (w_hold_data),
    .o_len  (w_hold_len)
  );

  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:  if (w_load) w_state_nxt = SHIFT;
      SHIFT: if (r_cnt == LEN_W'(1)) w_state_nxt = w_load ? SHIFT : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    w_out_nxt   = 1'b0;
    w_vld_nxt   = 1'b0;
    w_done_nxt  = 1'b0;
    if (w_load) begin
      w_out_nxt   = w_aligned[DATA_W-1];
      w_shift_nxt = w_aligned << 1;
      w_cnt_nxt   = w_src_len;
      w_vld_nxt   = 1'b1;
      w_done_nxt  = (w_src_len == LEN_W'(1));
    end else if (r_state == SHIFT && r_cnt != LEN_W'(1)) begin
      w_out_nxt   = r_shift[DATA_W-1];
      w_shift_nxt = r_shift << 1;
      w_cnt_nxt   = r_cnt - LEN_W'(1);
      w_vld_nxt   = 1'b1;
      w_done_nxt  = (r_cnt == LEN_W'(2));
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt       <= '0;
      r_out_bit   <= 1'b0;
      r_bit_valid <= 1'b0;
      r_word_done <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_cnt       <= w_cnt_nxt;
      r_out_bit   <= w_out_nxt;
      r_bit_valid <= w_vld_nxt;
      r_word_done <= w_done_nxt;
      r_busy      <= (w_state_nxt == SHIFT) | w_hold_full_nxt;
    end
  end

  always_ff @(posedge clock) begin
    r_shift <= w_shift_nxt;
  end

  assign bus.in_ready     = ~w_full;
  assign bus.sequence_out = r_out_bit;
  assign bus.bit_valid    = r_bit_valid;
  assign bus.word_done    = r_word_done;
  assign bus.busy         = r_busy;

endmodule

// File: tb/tb_bit_stream_serializer.sv
// Bench for bit_stream_serializer. The reference is a queue of pending bits:
// every accepted word appends its bits, and one bit leaves per cycle while any
// remain. The input is ready unless a whole accepted word is still waiting.
module tb_bit_stream_serializer;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  bit_stream_serializer_if #(.DATA_W(8), .LEN_W(4)) bus_if ();

  bit_stream_serializer #(.DATA_W(8), .LEN_W(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if)
  );

  typedef struct {
    logic b;
    logic first;
    logic last;
  } mbit_t;

  mbit_t q[$];
  int    n_cmp  = 0;
  int    n_fail = 0;
  int    n_step = 0;

  logic e_out   = 1'b0;
  logic e_vld   = 1'b0;
  logic e_done  = 1'b0;
  logic e_busy  = 1'b0;
  logic e_ready = 1'b1;

  // Behavioural "1011" detector fed by the DUT's serial output.
  logic [3:0] det_hist = '0;
  logic       det_next = 1'b0;
  logic       det_out  = 1'b0;

  logic       rv, rr;
  logic [7:0] rd;
  logic [3:0] rl;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required $finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s step %0d: observed %b expected %b", tag, n_step, obs, exp);
    end
  endtask

  task automatic model_edge(input logic v, input logic [7:0] d, input logic [3:0] l,
                            input logic r);
    int    n;
    mbit_t e;
    logic  hold;
    if (r) begin
      q.delete();
      e_out = 0; e_vld = 0; e_done = 0; e_busy = 0; e_ready = 1;
    end else begin
      if (v && e_ready) begin
        n = (l == 0 || l > 8) ? 8 : int'(l);
        for (int i = n - 1; i >= 0; i--)
          q.push_back('{b: d[i], first: (i == n - 1), last: (i == 0)});
      end
      if (q.size() > 0) begin
        e = q.pop_front();
        e_out = e.b; e_vld = 1; e_done = e.last;
      end else begin
        e_out = 0; e_vld = 0; e_done = 0;
      end
      hold = 0;
      foreach (q[i]) if (q[i].first) hold = 1;
      e_ready = !hold;
      e_busy  = e_vld || hold;
    end
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic [3:0] l,
                      input logic r);
    bus_if.in_valid = v;
    bus_if.in_data  = d;
    bus_if.in_len   = l;
    reset           = r;
    @(posedge clock);
    model_edge(v, d, l, r);
    #1;
    n_step++;
    chk("sequence_out", bus_if.sequence_out, e_out);
    chk("bit_valid",    bus_if.bit_valid,    e_vld);
    chk("word_done",    bus_if.word_done,    e_done);
    chk("busy",         bus_if.busy,         e_busy);
    chk("in_ready",     bus_if.in_ready,     e_ready);
    if (r) begin
      det_hist = '0; det_next = 0; det_out = 0;
    end else begin
      det_out = det_next;
      if (bus_if.bit_valid) det_hist = {det_hist[2:0], bus_if.sequence_out};
      det_next = bus_if.bit_valid && (det_hist == 4'b1011);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 4'h0, 1'b0);
  endtask

  // Hold in_valid until the word is taken (bounded).
  task automatic offer(input logic [7:0] d, input logic [3:0] l);
    logic took;
    took = 1'b0;
    for (int t = 0; t < 20 && !took; t++) begin
      took = e_ready;
      step(1'b1, d, l, 1'b0);
    end
  endtask

  initial begin
    bus_if.in_valid = 1'b0;
    bus_if.in_data  = '0;
    bus_if.in_len   = '0;

    // Reset, including an in_valid that must be ignored.
    step(1'b0, 8'h00, 4'h0, 1'b1);
    step(1'b1, 8'hFF, 4'h8, 1'b1);

    // 0x0B, 4 bits: 1,0,1,1 then idle; detector fires one cycle after.
    step(1'b1, 8'h0B, 4'h4, 1'b0);
    idle(3);
    chk("det_on_last_bit", det_out, 1'b0);
    idle(1);
    chk("det_after_last_bit", det_out, 1'b1);
    idle(2);

    // len 0 means the full word.
    step(1'b1, 8'hA5, 4'h0, 1'b0);
    idle(9);

    // Two words with in_valid held: 1,0,1,1,1,0 contiguous, hold fills.
    step(1'b1, 8'h0B, 4'h4, 1'b0);
    step(1'b1, 8'h02, 4'h2, 1'b0);
    idle(8);

    // Three words offered back to back.
    offer(8'hC6, 4'h5);
    offer(8'h3C, 4'h3);
    offer(8'h96, 4'h8);
    idle(20);

    // 1-bit words, clamped length, streaming of 1-bit words.
    step(1'b1, 8'h01, 4'h1, 1'b0);
    idle(2);
    offer(8'h00, 4'h1);
    offer(8'hFF, 4'h1);
    offer(8'h01, 4'h1);
    idle(3);
    step(1'b1, 8'h81, 4'hF, 1'b0);
    idle(10);

    // Reset on the 3rd bit of an 8-bit word with a word held.
    step(1'b1, 8'hC3, 4'h8, 1'b0);
    step(1'b1, 8'h5A, 4'h8, 1'b0);
    step(1'b0, 8'h00, 4'h0, 1'b0);
    step(1'b0, 8'h00, 4'h0, 1'b1);
    idle(4);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      rv = ($urandom_range(0, 9) < 7);
      rd = 8'($urandom);
      rl = 4'($urandom_range(0, 15));
      rr = ($urandom_range(0, 59) == 0);
      step(rv, rd, rl, rr);
    end
    idle(12);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
